// File: rtl/fbeb_pkg.sv
// Shared types and helpers for the fbeb round-robin arbiter slice.
package fbeb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Wrap increment that stays correct for non-power-of-2 requester counts.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fbeb_skid2.sv
// Two-entry valid/ready buffer; in_rdy depends only on the registered occupancy,
// so there is no combinational path from out_rdy back to in_rdy.
module fbeb_skid2 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [1:0]            cnt;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic                  push;
  logic                  pop;

  assign in_rdy   = (cnt < 2'd2);
  assign out_vld  = (cnt != 2'd0);
  assign out_data = head;
  assign push     = in_vld & in_rdy;
  assign pop      = out_vld & out_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= 2'd0;
      head <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the pre-edge
      // value of cnt, so the order of these statements does not matter.
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
      // Head takes the new beat when empty or when the old head leaves this cycle.
      if (push && (cnt == 2'd0 || pop)) begin
        head <= in_data;
      end else if (pop && cnt == 2'd2) begin
        head <= tail;
      end
    end
  end

  // NOTE: tail is a data-only register with no reset; it is never visible at
  // the output unless cnt says it holds a valid beat.
  always_ff @(posedge clk) begin
    if (push && !pop && cnt == 2'd1) begin
      tail <= in_data;
    end
  end

endmodule

// File: rtl/fbeb_rr_arb.sv
// Round-robin arbiter feeding one fbeb output channel through a 2-entry buffer.
// Define FBEB_RR_ARB_PKT_LOCK_EN to hold a grant until req_last (packet lock).
module fbeb_rr_arb
  import fbeb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_vld,
  output logic [NUM_REQ-1:0]            req_rdy,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [IDX_W-1:0]              out_src,
  output logic                          out_last,
  output logic                          arb_busy
);

  localparam int WORD_W = IDX_W + 1 + DATA_WIDTH;

  arb_state_e       state, state_next;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_next;
  logic [IDX_W-1:0] lock_idx, lock_idx_next;
  logic [IDX_W-1:0] grant;
  logic             grant_vld;
  logic [IDX_W-1:0] sel;
  logic             sel_vld;
  logic             buf_space;
  logic             push;
  logic [DATA_WIDTH-1:0] push_data;
  logic             push_last;
  logic [WORD_W-1:0] buf_out;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Walk from the farthest candidate back to rr_ptr so the nearest valid one wins.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_vld[wrap_add(rr_ptr, k)]) begin
        grant     = wrap_add(rr_ptr, k);
        grant_vld = 1'b1;
      end
    end
  end

  assign sel     = (state == ARB_LOCKED) ? lock_idx : grant;
  assign sel_vld = (state == ARB_LOCKED) | grant_vld;

  always_comb begin
    req_rdy = '0;
    if (!rst && sel_vld && buf_space) begin
      req_rdy[sel] = 1'b1;
    end
  end

  assign push      = |(req_vld & req_rdy);
  assign push_data = req_data[sel*DATA_WIDTH +: DATA_WIDTH];
  assign push_last = req_last[sel];
  assign arb_busy  = (state == ARB_LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      rr_ptr   <= '0;
      lock_idx <= '0;
    end else begin
      state    <= state_next;
      rr_ptr   <= rr_ptr_next;
      lock_idx <= lock_idx_next;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case/ifdef below can infer a latch.
  always_comb begin
    state_next    = state;
    rr_ptr_next   = rr_ptr;
    lock_idx_next = lock_idx;
`ifdef FBEB_RR_ARB_PKT_LOCK_EN
    if (push) begin
      case (state)
        ARB_IDLE: begin
          if (push_last) begin
            rr_ptr_next = IDX_W'(rr_next(32'(grant), NUM_REQ));
          end else begin
            state_next    = ARB_LOCKED;
            lock_idx_next = grant;
          end
        end
        ARB_LOCKED: begin
          if (push_last) begin
            state_next  = ARB_IDLE;
            rr_ptr_next = IDX_W'(rr_next(32'(lock_idx), NUM_REQ));
          end
        end
      endcase
    end
`else
    state_next    = ARB_IDLE;
    lock_idx_next = '0;
    if (push) begin
      rr_ptr_next = IDX_W'(rr_next(32'(grant), NUM_REQ));
    end
`endif
  end

  fbeb_skid2 #(
    .DATA_WIDTH (WORD_W)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (push),
    .in_rdy   (buf_space),
    .in_data  ({sel, push_last, push_data}),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (buf_out)
  );

  assign {out_src, out_last, out_data} = buf_out;

endmodule

// File: tb/tb_fbeb_rr_arb.sv
// Randomized and directed bench for fbeb_rr_arb against a queue-based reference model.
// Honors FBEB_RR_ARB_PKT_LOCK_EN the same way the design does.
module tb_fbeb_rr_arb;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_vld, req_rdy, req_last;
  logic [N*DW-1:0] req_data;
  logic          out_vld, out_rdy, out_last, arb_busy;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_src;

  always #5 clk = ~clk;

  fbeb_rr_arb #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_vld  (req_vld),
    .req_rdy  (req_rdy),
    .req_data (req_data),
    .req_last (req_last),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .out_src  (out_src),
    .out_last (out_last),
    .arb_busy (arb_busy)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            src;
    logic          last;
  } beat_t;

  beat_t q[$];
  int    m_rr;
  bit    m_locked;
  int    m_lock;
  int    n_vec;
  int    n_err;
  bit    armed;
  int    pop_log[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Which requester the arbiter should be serving given the model state.
  function automatic int m_sel(input logic [N-1:0] vld);
    if (m_locked) return m_lock;
    for (int k = 0; k < N; k++) begin
      if (vld[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  task automatic step(input logic [N-1:0] vld, input logic [N-1:0] last,
                      input logic ordy, input logic r);
    int           sel;
    logic [N-1:0] exp_rdy;
    beat_t        b;
    @(negedge clk);
    req_vld  = vld;
    req_last = last;
    out_rdy  = ordy;
    rst      = r;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
    #1;
    sel     = m_sel(vld);
    exp_rdy = '0;
    if (!r && sel >= 0 && q.size() < 2) exp_rdy[sel] = 1'b1;
    if (armed) begin
      check("req_rdy", 64'(req_rdy), 64'(exp_rdy));
      check("out_vld", 64'(out_vld), 64'(q.size() != 0));
      check("arb_busy", 64'(arb_busy), 64'(m_locked));
      if (q.size() != 0) begin
        check("out_data", 64'(out_data), 64'(q[0].data));
        check("out_src", 64'(out_src), 64'(q[0].src));
        check("out_last", 64'(out_last), 64'(q[0].last));
      end
      if (out_vld === 1'b1 && ordy && !r) pop_log.push_back(int'(out_src));
    end
    if (sel >= 0) begin
      b.data = req_data[sel*DW +: DW];
      b.src  = sel;
      b.last = last[sel];
    end
    @(posedge clk);
    if (r) begin
      q.delete();
      m_rr     = 0;
      m_locked = 0;
      m_lock   = 0;
    end else begin
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (exp_rdy != '0 && vld[sel]) begin
        q.push_back(b);
`ifdef FBEB_RR_ARB_PKT_LOCK_EN
        if (!m_locked) begin
          if (b.last) m_rr = (sel + 1) % N;
          else begin
            m_locked = 1;
            m_lock   = sel;
          end
        end else if (b.last) begin
          m_locked = 0;
          m_rr     = (m_lock + 1) % N;
        end
`else
        m_rr = (sel + 1) % N;
`endif
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    req_vld  = '0;
    req_last = '0;
    req_data = '0;
    out_rdy  = 1'b0;
    n_vec    = 0;
    n_err    = 0;
    armed    = 0;
    m_rr     = 0;
    m_locked = 0;
    m_lock   = 0;

    repeat (2) step('0, '0, 1'b0, 1'b1);
    armed = 1;
    step(4'b1111, 4'b1111, 1'b1, 1'b1);
    #1;
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_src", 64'(out_src), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);

    // All requesters streaming single-beat packets: strict 0,1,2,3 rotation.
    pop_log.delete();
    repeat (9) step(4'b1111, 4'b1111, 1'b1, 1'b0);
    check("t1_pops", 64'(pop_log.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < pop_log.size()) check("t1_src", 64'(pop_log[i]), 64'(i % 4));
    end

    // Req1 three-beat packet while req2 waits.
    step('0, '0, 1'b1, 1'b1);
    step(4'b0110, 4'b0100, 1'b1, 1'b0);
    step(4'b0110, 4'b0100, 1'b1, 1'b0);
    step(4'b0110, 4'b0110, 1'b1, 1'b0);
    repeat (3) step(4'b0100, 4'b0100, 1'b1, 1'b0);

    // Downstream stall for five cycles, then drain.
    repeat (5) step(4'b1111, 4'($urandom), 1'b0, 1'b0);
    repeat (6) step(4'b1111, 4'($urandom), 1'b1, 1'b0);
    repeat (4) step('0, '0, 1'b1, 1'b0);

    // Only req3 valid with rr_ptr parked at 3: search wraps back to 3.
    step('0, '0, 1'b1, 1'b1);
    step(4'b0100, 4'b0100, 1'b1, 1'b0);
    repeat (4) step(4'b1000, 4'b1000, 1'b1, 1'b0);

    // Reset in the middle of a four-beat packet with the output stalled.
    step('0, '0, 1'b1, 1'b1);
    repeat (2) step(4'b0001, 4'b0000, 1'b0, 1'b0);
    step(4'b0001, 4'b0000, 1'b0, 1'b1);
    step(4'b1111, 4'b1111, 1'b1, 1'b0);
    step(4'b1111, 4'b1111, 1'b1, 1'b0);

    // Two multi-beat packets from req0 and req1 competing.
    step('0, '0, 1'b1, 1'b1);
    step(4'b0011, 4'b0000, 1'b1, 1'b0);
    step(4'b0011, 4'b0000, 1'b1, 1'b0);
    step(4'b0011, 4'b0001, 1'b1, 1'b0);
    step(4'b0011, 4'b0010, 1'b1, 1'b0);
    repeat (3) step(4'b0011, 4'b0011, 1'b1, 1'b0);

    // Random traffic, back-pressure and occasional resets.
    for (int t = 0; t < 1500; t++) begin
      logic [N-1:0] v, l;
      for (int i = 0; i < N; i++) begin
        v[i] = ($urandom_range(0, 99) < 60);
        l[i] = ($urandom_range(0, 99) < 35);
      end
      step(v, l, ($urandom_range(0, 99) < 75), ($urandom_range(0, 299) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
